spi_slave_port: RTL

SPI mode-0 responder peripheral. It sits on the far end of the processor's SPI master port (spi_clk/mosi/miso, with ss decoded from spi_addr by glue logic) and lets an FPGA-side device exchange bytes with the core. All SPI inputs are oversampled in the clk_i domain. Received bytes are presented on a valid/ready interface, and transmit bytes are queued through a one-entry holding register.

---
 rtl/spi_slave_port.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_port.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_port
//  Purpose  : SPI mode-0 responder. SCK, MOSI and SS are oversampled in the
//             clk_i domain. Received frames are offered on a valid/ready
//             interface. Transmit bytes are queued through a one-entry
//             holding register.
//  Ports    : clk_i, reset_i (async, active low)
//             spi_clk_i, mosi_i, ss_ni, miso_o   - SPI pins
//             rx_data_o, rx_valid_o, rx_ready_i  - receive stream
//             tx_data_i, tx_wr_i, tx_full_o      - transmit holding register
//             overrun_o, underrun_o, abort_o     - sticky errors, clr_i clears
//             busy_o                             - synchronized select active
//  Options  : `define SPI_SLAVE_RX_FIFO_EN selects an RX_DEPTH-entry FIFO
//             (RX_DEPTH a power of 2, at least 2). Otherwise a single
//             holding register is used.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_port #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RX_DEPTH    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  spi_clk_i,
    input  logic                  mosi_i,
    input  logic                  ss_ni,
    output logic                  miso_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_wr_i,
    output logic                  tx_full_o,
    output logic                  overrun_o,
    output logic                  underrun_o,
    output logic                  abort_o,
    input  logic                  clr_i,
    output logic                  busy_o
);

    localparam int                 c_cnt_w    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [0:0]         c_st_idle   = 1'b0;
    localparam logic [0:0]         c_st_select = 1'b1;

    // ------------------------------------------------------------------
    // Input synchronizers plus one extra SCK copy for edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sck_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_ni};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck, w_mosi, w_ss, w_sck_rise, w_sck_fall;
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;

    // ------------------------------------------------------------------
    // Frame FSM, shift registers, TX holding register, TX-side flags
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_tx_hold;
    logic                  r_tx_full;
    logic                  r_underrun;
    logic                  r_abort;
    logic                  r_push;
    logic [DATA_WIDTH-1:0] r_push_data;
    // A boundary reload found the holding register empty. The frame only
    // counts as an underrun once its first SCK rise arrives; if the master
    // deselects instead, no frame was started and nothing is flagged.
    logic                  r_reload_empty;

    logic w_start, w_selected, w_boundary_load, w_load;
    logic w_set_underrun, w_set_abort;

    assign w_start         = (r_state == c_st_idle) && !w_ss;
    assign w_selected      = (r_state == c_st_select) && !w_ss;
    assign w_boundary_load = w_selected && w_sck_fall && (r_bit_cnt == '0);
    assign w_load          = w_start || w_boundary_load;
    assign w_set_underrun  = (w_start && !r_tx_full) ||
                             (w_selected && w_sck_rise && (r_bit_cnt == '0) && r_reload_empty);
    assign w_set_abort     = (r_state == c_st_select) && w_ss && (r_bit_cnt != '0);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state        <= c_st_idle;
            r_bit_cnt      <= '0;
            r_rx_shift     <= '0;
            r_tx_shift     <= '0;
            r_tx_hold      <= '0;
            r_tx_full      <= 1'b0;
            r_underrun     <= 1'b0;
            r_abort        <= 1'b0;
            r_push         <= 1'b0;
            r_push_data    <= '0;
            r_reload_empty <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_underrun <= w_set_underrun | (r_underrun & ~clr_i);
            r_abort    <= w_set_abort | (r_abort & ~clr_i);

            // A load takes the old byte; a same-cycle write becomes pending.
            if (w_load) begin
                r_tx_full <= tx_wr_i;
                if (tx_wr_i) r_tx_hold <= tx_data_i;
            end else if (tx_wr_i) begin
                r_tx_hold <= tx_data_i;
                r_tx_full <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (!w_ss) begin
                        r_state        <= c_st_select;
                        r_tx_shift     <= r_tx_full ? r_tx_hold : '0;
                        r_bit_cnt      <= '0;
                        r_reload_empty <= 1'b0;
                    end
                end
                default: begin
                    if (w_ss) begin
                        // Deselect; any partial byte is simply never pushed.
                        r_state        <= c_st_idle;
                        r_bit_cnt      <= '0;
                        r_reload_empty <= 1'b0;
                    end else begin
                        if (w_sck_rise) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                            if (r_bit_cnt == '0) r_reload_empty <= 1'b0;
                            if (r_bit_cnt == c_last_bit) begin
                                r_bit_cnt   <= '0;
                                r_push      <= 1'b1;
                                r_push_data <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_sck_fall) begin
                            if (r_bit_cnt == '0) begin
                                // Frame boundary: queue the next byte for a
                                // back-to-back frame.
                                r_tx_shift     <= r_tx_full ? r_tx_hold : '0;
                                r_reload_empty <= !r_tx_full;
                            end else begin
                                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign tx_full_o  = r_tx_full;
    assign underrun_o = r_underrun;
    assign abort_o    = r_abort;
    assign busy_o     = ~w_ss;
    assign miso_o     = ~w_ss & r_tx_shift[DATA_WIDTH-1];

    // ------------------------------------------------------------------
    // RX buffer
    // ------------------------------------------------------------------
    logic w_pop, w_accept;
    logic r_overrun;
    assign w_pop     = rx_valid_o && rx_ready_i;
    assign overrun_o = r_overrun;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int                 c_ptr_w = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int                 c_num_w = $clog2(RX_DEPTH + 1);
    localparam logic [c_num_w-1:0] c_depth = c_num_w'(RX_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RX_DEPTH];
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic [c_num_w-1:0]    r_count;

    // A pop in the same cycle frees the slot the push needs.
    assign w_accept = r_push && ((r_count != c_depth) || w_pop);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= (r_push && !w_accept) | (r_overrun & ~clr_i);
            if (w_accept) begin
                r_mem[r_wptr] <= r_push_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign rx_valid_o = (r_count != '0);
    assign rx_data_o  = r_mem[r_rptr];
`else
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic [31:0]           w_unused_rx_depth;
    assign w_unused_rx_depth = 32'(RX_DEPTH);

    assign w_accept = r_push && (!r_rx_valid || w_pop);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= (r_push && !w_accept) | (r_overrun & ~clr_i);
            if (w_accept) begin
                r_rx_data  <= r_push_data;
                r_rx_valid <= 1'b1;
            end else if (w_pop) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
`endif

endmodule
`default_nettype wire
